// File: rtl/rf_wport_arb_pkg.sv
// Shared widths and arbiter state encoding for the register-file write-port arbiter.
package rf_wport_arb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} arbState_e;

endpackage

// File: rtl/rf_wport_arb_wb_fifo.sv
// Accelerator write-back FIFO: in-order queue of (rd, data) with per-entry source-match vector.
module wb_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [REG_W-1:0]      pushRd_i,
  input  logic [DATA_W-1:0]     pushData_i,
  input  logic                  pop_i,
  input  logic [REG_W-1:0]      rs_i,
  input  logic [REG_W-1:0]      rt_i,
  output logic [REG_W-1:0]      headRd_o,
  output logic [DATA_W-1:0]     headData_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]      hitVec_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]  count_q;

  always_comb begin
    valid_d = valid_q;
    if (pop_i)  valid_d[rdPtr_q] = 1'b0;
    if (push_i) valid_d[wrPtr_q] = 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop_i)  rdPtr_q <= rdPtr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      rd_q[wrPtr_q]   <= pushRd_i;
      data_q[wrPtr_q] <= pushData_i;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hitVec_o[i] = valid_q[i] && (rd_q[i] != '0) && ((rd_q[i] == rs_i) || (rd_q[i] == rt_i));
    end
  end

  assign headRd_o   = rd_q[rdPtr_q];
  assign headData_o = data_q[rdPtr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline WB has priority, queued accelerator results
// drain in idle slots, and a starvation FSM requests a WB bubble when the queue is blocked.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite_wb,
  input  logic [REG_W-1:0]  rd_wb,
  input  logic [DATA_W-1:0] wbdata,
  input  logic              acc_valid,
  input  logic [REG_W-1:0]  acc_rd,
  input  logic [DATA_W-1:0] acc_data,
  output logic              acc_ready,
  input  logic [REG_W-1:0]  rs_id,
  input  logic [REG_W-1:0]  rt_id,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pend_hit,
  output logic              stall_req
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BLK_W = $clog2(STARVE_LIM) + 1;

  logic [CNT_W-1:0]  count, countNext;
  logic [REG_W-1:0]  headRd;
  logic [DATA_W-1:0] headData;
  logic [DEPTH-1:0]  hitVec;
  logic              pipeOwn, push, pop, blocked;

  arbState_e         state_q;
  logic [BLK_W-1:0]  blkCnt_q;
  logic              stall_q;

  assign pipeOwn   = regwrite_wb && (rd_wb != '0);
  assign acc_ready = !rst && (count < CNT_W'(DEPTH));
  assign push      = acc_valid && acc_ready && (acc_rd != '0);
  assign pop       = !rst && !pipeOwn && (count != '0);
  assign blocked   = pipeOwn && (count != '0);
  assign pend_hit  = !rst && (|hitVec);
  assign stall_req = stall_q && !rst;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .pushRd_i   (acc_rd),
    .pushData_i (acc_data),
    .pop_i      (pop),
    .rs_i       (rs_id),
    .rt_i       (rt_id),
    .headRd_o   (headRd),
    .headData_o (headData),
    .count_o    (count),
    .hitVec_o   (hitVec)
  );

  always_comb begin
    countNext = count;
    if (push && !pop)      countNext = count + CNT_W'(1);
    else if (pop && !push) countNext = count - CNT_W'(1);
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (pipeOwn) begin
        rf_we    = 1'b1;
        rf_waddr = rd_wb;
        rf_wdata = wbdata;
      end else if (count != '0) begin
        rf_we    = 1'b1;
        rf_waddr = headRd;
        rf_wdata = headData;
      end
    end
  end

  // Force after STARVE_LIM consecutive blocked cycles; any pop releases the bubble request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      blkCnt_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (countNext != '0) state_q <= WAIT;
        end
        WAIT: begin
          if (pop) begin
            blkCnt_q <= '0;
            if (countNext == '0) state_q <= IDLE;
          end else if (blocked) begin
            if (blkCnt_q == BLK_W'(STARVE_LIM - 1)) begin
              state_q <= FORCE;
              stall_q <= 1'b1;
            end
            if (blkCnt_q != '1) blkCnt_q <= blkCnt_q + 1'b1;
          end
        end
        FORCE: begin
          if (pop) begin
            blkCnt_q <= '0;
            stall_q  <= 1'b0;
            state_q  <= (countNext == '0) ? IDLE : WAIT;
          end else if (blocked && (blkCnt_q != '1)) begin
            blkCnt_q <= blkCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
